// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per request and presents it to decode.
// Latency: request in the cycle after an ack, instruction valid two cycles after the request with a 1-cycle memory.
// Backpressure: the instruction is held stable until execute acks; one outstanding memory request at most.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        zero,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        fetch_fault,
    output logic [31:0] instr_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        req_q, req_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;

    // Next-PC selection: jalr beats jal beats a taken branch beats fall-through.
    always_comb begin
        next_pc = instr_pc_q + 32'd4;
        if (is_jalr) begin
            next_pc = (rs1_val + imm) & 32'hFFFF_FFFE;
        end else if (is_jal || (branch && zero)) begin
            next_pc = instr_pc_q + imm;
        end
    end

    // Next-state and datapath updates. Reset leaves the FSM in ISSUE with the request
    // low, so the first ISSUE visit spends one cycle raising the request; every later
    // entry into ISSUE raises it on the same edge as the transition.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        req_d         = req_q;
        fault_d       = fault_q;
        count_d       = count_q;
        case (state_q)
            ST_ISSUE: begin
                if (req_q) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
                    count_d       = count_q + 32'd1;
                    instr_valid_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        req_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        // Misaligned target: park here and keep the old PC for debug.
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                req_d         = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State register with asynchronous active-low reset to the reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ISSUE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            req_q         <= req_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_val = 32'd0;
    logic        fetch_fault;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;

    // memory model controls (written only by the stimulus process)
    int lat = 1;
    int spur_req = 0;
    // memory model state (written only by the memory process)
    int spur_seen = 0;
    int cnt = 0;
    bit pend = 1'b0;
    logic [31:0] paddr = 32'd0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ack(instr_ack),
        .branch(branch), .zero(zero), .is_jal(is_jal), .is_jalr(is_jalr),
        .imm(imm), .rs1_val(rs1_val),
        .fetch_fault(fetch_fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5013;
    endfunction

    // Instruction memory: answers a request after lat cycles, drops it on reset.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
            if (spur_req != spur_seen) begin
                spur_seen   = spur_req;
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
            end
        end
    end

    task automatic apply_reset(input int latency);
        rst_n = 1'b0; instr_ack = 1'b0; branch = 1'b0; zero = 1'b0;
        is_jal = 1'b0; is_jalr = 1'b0; imm = 32'd0; rs1_val = 32'd0;
        lat = latency;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_req(output logic [31:0] a, output bit ok);
        ok = 1'b0;
        a  = 32'hXXXX_XXXX;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                a  = imem_addr;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_with(input logic br, input logic z, input logic j, input logic jr,
                            input logic [31:0] im, input logic [31:0] rs);
        branch = br; zero = z; is_jal = j; is_jalr = jr; imm = im; rs1_val = rs;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0; branch = 1'b0; zero = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        imm = 32'd0; rs1_val = 32'd0;
    endtask

    // wait for the instruction, ack it with the given controls, wait for the next request
    task automatic step(input logic br, input logic z, input logic j, input logic jr,
                        input logic [31:0] im, input logic [31:0] rs,
                        output logic [31:0] a, output bit ok);
        bit v_ok;
        wait_valid(v_ok);
        ack_with(br, z, j, jr, im, rs);
        wait_req(a, ok);
        ok = ok && v_ok;
    endtask

    task automatic test_reset;
        apply_reset(1);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h want 0", instr_count); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (pc_plus4 !== 32'd4) begin errors++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        bit ok;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL seq_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_cycle1: got req=%b valid=%b want 0 0", imem_req, instr_valid); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'd0) || instr_pc !== 32'd0) begin errors++; $display("FAIL seq_cycle2: got valid=%b instr=%h pc=%h want 1 %h 0", instr_valid, instr, instr_pc, mem_word(32'd0)); end
        ack_with(0, 0, 0, 0, 32'd0, 32'd0);
        wait_req(a, ok);
        checks++; if (!ok || a !== 32'd4) begin errors++; $display("FAIL seq_addr4: got %h ok=%b want 4", a, ok); end
        wait_valid(ok);
        checks++; if (!ok || instr_pc !== 32'd4 || instr !== mem_word(32'd4)) begin errors++; $display("FAIL seq_instr4: got pc=%h instr=%h want 4 %h", instr_pc, instr, mem_word(32'd4)); end
        step(0, 0, 0, 0, 32'd0, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'd8) begin errors++; $display("FAIL seq_addr8: got %h ok=%b want 8", a, ok); end
        step(0, 0, 0, 0, 32'd0, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'd12) begin errors++; $display("FAIL seq_addr12: got %h ok=%b want c", a, ok); end
        checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d want 3", instr_count); end
    endtask

    task automatic test_branch;
        logic [31:0] a;
        bit ok;
        step(0, 0, 1, 0, 32'h0000_0034, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h40) begin errors++; $display("FAIL br_setup: got %h want 40", a); end
        wait_valid(ok);
        checks++; if (!ok || instr_pc !== 32'h40 || pc_plus4 !== 32'h44) begin errors++; $display("FAIL br_pc_plus4: got pc=%h p4=%h want 40 44", instr_pc, pc_plus4); end
        step(1, 1, 0, 0, 32'hFFFF_FFF0, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h30) begin errors++; $display("FAIL br_taken: got %h want 30", a); end
        step(0, 0, 1, 0, 32'h0000_0010, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h40) begin errors++; $display("FAIL br_back: got %h want 40", a); end
        step(1, 0, 0, 0, 32'hFFFF_FFF0, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h44) begin errors++; $display("FAIL br_not_taken: got %h want 44", a); end
        step(0, 1, 0, 0, 32'h0000_0100, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h48) begin errors++; $display("FAIL br_zero_only: got %h want 48", a); end
    endtask

    task automatic test_jumps;
        logic [31:0] a;
        bit ok;
        bit bad;
        step(0, 0, 1, 0, 32'h0000_00B8, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h100) begin errors++; $display("FAIL jal_setup: got %h want 100", a); end
        step(0, 0, 1, 0, 32'h0000_0020, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'h120) begin errors++; $display("FAIL jal: got %h want 120", a); end
        // jalr with jal and taken branch also raised: jalr must win
        step(1, 1, 1, 1, 32'hFFFF_FFFF, 32'h0000_0205, a, ok);
        checks++; if (!ok || a !== 32'h204) begin errors++; $display("FAIL jalr_aligned: got %h want 204", a); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL jalr_no_fault: got %b want 0", fetch_fault); end
        wait_valid(ok);
        ack_with(0, 0, 0, 1, 32'h0000_0002, 32'h0000_0201);
        checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL jalr_fault: got fault=%b req=%b valid=%b want 1 0 0", fetch_fault, imem_req, instr_valid); end
        checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL fault_pc_kept: got %h want 204", imem_addr); end
        // everything is ignored in FAULT
        bad = 1'b0;
        spur_req++;
        instr_ack = 1'b1; is_jal = 1'b1; imm = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1) bad = 1'b1;
        end
        instr_ack = 1'b0; is_jal = 1'b0; imm = 32'd0;
        checks++; if (bad) begin errors++; $display("FAIL fault_sticky: got req/valid/fault deviation want 0/0/1"); end
        checks++; if (instr_count !== 32'd12) begin errors++; $display("FAIL fault_count: got %0d want 12", instr_count); end
    endtask

    task automatic test_async_reset_fault;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL arst_fault_ctl: got fault=%b req=%b valid=%b want 0 0 0", fetch_fault, imem_req, instr_valid); end
        checks++; if (instr !== 32'h13 || instr_pc !== 32'd0 || instr_count !== 32'd0 || imem_addr !== 32'd0) begin errors++; $display("FAIL arst_fault_dat: got instr=%h ipc=%h cnt=%h addr=%h want 13 0 0 0", instr, instr_pc, instr_count, imem_addr); end
        lat = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL arst_fault_refetch: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_stall;
        logic [31:0] a;
        logic [31:0] held;
        bit ok;
        bit bad;
        apply_reset(5);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL stall_req: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        bad = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            instr_ack = (i == 2);
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) bad = 1'b1;
        end
        instr_ack = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL stall_wait: got req or valid during wait want 0"); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL stall_ack_in_wait: got %0d want 0", instr_count); end
        wait_valid(ok);
        held = mem_word(32'd0);
        checks++; if (!ok || instr !== held) begin errors++; $display("FAIL stall_instr: got %h want %h", instr, held); end
        spur_req++;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (instr !== held || instr_valid !== 1'b1 || imem_req !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stall_hold: got unstable instr=%h valid=%b req=%b want %h 1 0", instr, instr_valid, imem_req, held); end
        ack_with(0, 0, 0, 0, 32'd0, 32'd0);
        wait_req(a, ok);
        checks++; if (!ok || a !== 32'd4 || instr_count !== 32'd1) begin errors++; $display("FAIL stall_next: got addr=%h cnt=%0d want 4 1", a, instr_count); end
    endtask

    task automatic test_wrap;
        logic [31:0] a;
        bit ok;
        apply_reset(1);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 32'hFFFF_FFFC, 32'd0, a, ok);
        checks++; if (!ok || a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h want fffffffc", a); end
        wait_valid(ok);
        checks++; if (!ok || pc_plus4 !== 32'd0) begin errors++; $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); end
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        ack_with(0, 0, 0, 0, 32'd0, 32'd0);
        wait_req(a, ok);
        checks++; if (!ok || a !== 32'd0) begin errors++; $display("FAIL wrap_addr: got %h want 0", a); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h want 0", instr_count); end
    endtask

    task automatic test_async_reset_wait;
        @(negedge clk);
        lat = 5;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL arst_wait_ctl: got req=%b valid=%b fault=%b want 0 0 0", imem_req, instr_valid, fetch_fault); end
        checks++; if (instr !== 32'h13 || instr_pc !== 32'd0 || imem_addr !== 32'd0 || instr_count !== 32'd0) begin errors++; $display("FAIL arst_wait_dat: got instr=%h ipc=%h addr=%h cnt=%h want 13 0 0 0", instr, instr_pc, imem_addr, instr_count); end
        repeat (2) @(negedge clk);
        lat = 1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL arst_wait_refetch: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'd0)) begin errors++; $display("FAIL arst_wait_instr: got valid=%b instr=%h want 1 %h", instr_valid, instr, mem_word(32'd0)); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch;
        test_jumps;
        test_async_reset_fault;
        test_stall;
        test_wrap;
        test_async_reset_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
